// File: rtl/mem_port_arb.sv
// Shares one memory port between instruction fetch (read-only) and load/store, one transaction at a time.
// Latency: grant in cycle N, o_mem_req in N+1, response pulse one cycle after i_mem_rvalid; issue-to-issue spacing is at least 4 cycles.
// Backpressure: o_mem_req and its fields hold until i_mem_ready; requesters wait for a grant while a transaction is outstanding.
module mem_port_arb #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  output logic        o_if_err,
  input  logic        i_ls_req,
  input  logic        i_ls_we,
  input  logic [31:0] i_ls_addr,
  input  logic [31:0] i_ls_wdata,
  input  logic [3:0]  i_ls_bmask,
  output logic        o_ls_gnt,
  output logic        o_ls_rvalid,
  output logic [31:0] o_ls_rdata,
  output logic        o_ls_err,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  input  logic        i_mem_ready,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  // A zero timeout still gets a 1-bit counter so the declarations stay legal.
  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
  } mem_req_t;

  state_t        state_q;
  logic          owner_q;    // 1: load/store owns the transaction, 0: fetch
  logic          last_ls_q;  // 1: most recent grant went to load/store
  logic [CW-1:0] cnt_q;
  mem_req_t      req_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic grant_if;
  logic grant_ls;
  logic timeout_hit;
  logic resp_if;
  logic resp_ls;

  // Arbitration: load/store wins unless both request and it took the previous grant.
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (state_q == IDLE && !i_reset) begin
      if (i_ls_req && i_if_req) begin
        if (last_ls_q) grant_if = 1'b1;
        else           grant_ls = 1'b1;
      end else if (i_ls_req) begin
        grant_ls = 1'b1;
      end else if (i_if_req) begin
        grant_if = 1'b1;
      end
    end
  end

  assign timeout_hit = (TIMEOUT_CYC != 0) && (int'(cnt_q) == TIMEOUT_CYC - 1);

  // Transaction sequencer: latch on grant, issue, wait for response or timeout, return.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_ls_q <= 1'b0;
      cnt_q     <= '0;
      req_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_ls) begin
            req_q     <= '{we: i_ls_we, addr: i_ls_addr, wdata: i_ls_wdata, bmask: i_ls_bmask};
            owner_q   <= 1'b1;
            last_ls_q <= 1'b1;
            state_q   <= ISSUE;
          end else if (grant_if) begin
            req_q     <= '{we: 1'b0, addr: i_if_addr, wdata: 32'd0, bmask: 4'hF};
            owner_q   <= 1'b0;
            last_ls_q <= 1'b0;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          if (i_mem_ready) begin
            cnt_q   <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != {CW{1'b1}}) cnt_q <= cnt_q + 1'b1;
          // A real response beats a timeout landing in the same cycle.
          if (i_mem_rvalid) begin
            rdata_q <= req_q.we ? 32'd0 : i_mem_rdata;
            err_q   <= 1'b0;
            state_q <= RESP;
          end else if (timeout_hit) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_if = (state_q == RESP) && !owner_q;
  assign resp_ls = (state_q == RESP) &&  owner_q;

  assign o_if_gnt    = grant_if;
  assign o_if_rvalid = resp_if;
  assign o_if_rdata  = resp_if ? rdata_q : 32'd0;
  assign o_if_err    = resp_if & err_q;

  assign o_ls_gnt    = grant_ls;
  assign o_ls_rvalid = resp_ls;
  assign o_ls_rdata  = resp_ls ? rdata_q : 32'd0;
  assign o_ls_err    = resp_ls & err_q;

  assign o_mem_req   = (state_q == ISSUE);
  assign o_mem_we    = req_q.we;
  assign o_mem_addr  = req_q.addr;
  assign o_mem_wdata = req_q.wdata;
  assign o_mem_bmask = req_q.bmask;

endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb with a scoreboard of expected responses.
// Latency: checks grant, issue, response and timeout cycle positions explicitly.
// Backpressure: a small memory model stalls ready and delays or withholds responses on request.
module tb_mem_port_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        ls_req, ls_we;
  logic [31:0] ls_addr, ls_wdata;
  logic [3:0]  ls_bmask;
  logic        ls_gnt, ls_rvalid, ls_err;
  logic [31:0] ls_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_bmask;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_port_arb #(.TIMEOUT_CYC(4)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_if_req     (if_req),
    .i_if_addr    (if_addr),
    .o_if_gnt     (if_gnt),
    .o_if_rvalid  (if_rvalid),
    .o_if_rdata   (if_rdata),
    .o_if_err     (if_err),
    .i_ls_req     (ls_req),
    .i_ls_we      (ls_we),
    .i_ls_addr    (ls_addr),
    .i_ls_wdata   (ls_wdata),
    .i_ls_bmask   (ls_bmask),
    .o_ls_gnt     (ls_gnt),
    .o_ls_rvalid  (ls_rvalid),
    .o_ls_rdata   (ls_rdata),
    .o_ls_err     (ls_err),
    .o_mem_req    (mem_req),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_mem_bmask  (mem_bmask),
    .i_mem_ready  (mem_ready),
    .i_mem_rvalid (mem_rvalid),
    .i_mem_rdata  (mem_rdata)
  );

  typedef struct {
    bit          ls;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // memory model knobs
  int          lat_cfg    = 1;
  int          lat_left   = 0;
  int          stall_left = 0;
  bit          resp_en    = 1'b1;
  bit          inject_rv  = 1'b0;
  logic [31:0] resp_data  = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input bit ls, input logic [31:0] d, input bit e);
    exp_t x;
    x.ls    = ls;
    x.rdata = d;
    x.err   = e;
    sb.push_back(x);
  endtask

  task automatic check_outputs_zero(input string p);
    check({p, "_ctl"}, 32'({if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err, mem_req, mem_we}), 0);
    check({p, "_if_rdata"}, if_rdata, 0);
    check({p, "_ls_rdata"}, ls_rdata, 0);
    check({p, "_mem_addr"}, mem_addr, 0);
    check({p, "_mem_wdata"}, mem_wdata, 0);
    check({p, "_mem_bmask"}, 32'(mem_bmask), 0);
  endtask

  task automatic drain(input string p);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    check({p, "_drain"}, sb.size(), 0);
  endtask

  // Memory model: stalls ready, answers after lat_cfg cycles, or injects a stray response.
  initial begin : mem_model
    mem_ready  = 1'b1;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    forever begin
      @(negedge clk);
      if (mem_req && mem_ready) lat_left = lat_cfg;
      else if (mem_req && !mem_ready && stall_left > 0) stall_left--;
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'd0;
      mem_ready  = (stall_left == 0);
      if (lat_left > 0) begin
        lat_left--;
        if (lat_left == 0 && resp_en) begin
          mem_rvalid = 1'b1;
          mem_rdata  = resp_data;
        end
      end
      if (inject_rv) begin
        mem_rvalid = 1'b1;
        mem_rdata  = resp_data;
        inject_rv  = 1'b0;
      end
    end
  end

  // Response monitor: every rvalid pulse must match the oldest expected response.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (if_rvalid || ls_rvalid) begin
        check("rv_onehot", 32'(if_rvalid & ls_rvalid), 0);
        check("rv_gnt_overlap", 32'(if_rvalid ? if_gnt : ls_gnt), 0);
        if (sb.size() == 0) begin
          check("rv_unexpected", 32'({if_rvalid, ls_rvalid}), 0);
        end else begin
          e = sb.pop_front();
          check("rv_owner", 32'(ls_rvalid), 32'(e.ls));
          check("rv_rdata", ls_rvalid ? ls_rdata : if_rdata, e.rdata);
          check("rv_err", 32'(ls_rvalid ? ls_err : if_err), 32'(e.err));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no finish, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int got, prev, cyc, w;
    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_bmask = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset");

    // single fetch read
    resp_data = 32'hDEADBEEF; lat_cfg = 1;
    tick(); if_req = 1'b1; if_addr = 32'h100; push_exp(1'b0, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    check("t1_if_gnt", 32'(if_gnt), 1);
    check("t1_ls_gnt", 32'(ls_gnt), 0);
    tick(); if_req = 1'b0;
    @(negedge clk);
    check("t1_mem_req", 32'(mem_req), 1);
    check("t1_mem_addr", mem_addr, 32'h100);
    check("t1_mem_we", 32'(mem_we), 0);
    check("t1_mem_bmask", 32'(mem_bmask), 'hF);
    check("t1_mem_wdata", mem_wdata, 0);
    tick(); @(negedge clk); check("t1_rv_n2", 32'(if_rvalid), 0);
    tick(); @(negedge clk); check("t1_rv_n3", 32'(if_rvalid), 1);
    tick(); @(negedge clk); check("t1_rv_n4", 32'(if_rvalid), 0);

    // contention from reset: LS, IF, LS, IF
    resp_data = 32'hCAFE0000;
    tick(); rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h300;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h2000; ls_wdata = 32'h11223344; ls_bmask = 4'b0011;
    push_exp(1'b1, 32'd0, 1'b0); push_exp(1'b0, 32'hCAFE0000, 1'b0);
    push_exp(1'b1, 32'd0, 1'b0); push_exp(1'b0, 32'hCAFE0000, 1'b0);
    tick(); rst = 1'b0;
    got = 0; prev = 0; cyc = 0;
    while (got < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (ls_gnt || if_gnt) begin
        check("t2_order", 32'(ls_gnt), (got % 2 == 0) ? 1 : 0);
        check("t2_gnt_onehot", 32'(ls_gnt & if_gnt), 0);
        if (got > 0) check("t2_spacing", cyc - prev, 4);
        prev = cyc;
        got++;
      end else if (mem_req && mem_we) begin
        check("t2_wr_addr", mem_addr, 32'h2000);
        check("t2_wr_wdata", mem_wdata, 32'h11223344);
        check("t2_wr_bmask", 32'(mem_bmask), 'h3);
      end
    end
    check("t2_grants", got, 4);
    tick(); if_req = 1'b0; ls_req = 1'b0;
    drain("t2");

    // backpressure: ready low for 5 ISSUE cycles
    resp_data = 32'h55AA55AA; stall_left = 5;
    tick(); ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h44; ls_wdata = 32'h9999; ls_bmask = 4'hC;
    push_exp(1'b1, 32'h55AA55AA, 1'b0);
    @(negedge clk); check("t3_gnt", 32'(ls_gnt), 1);
    tick(); ls_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t3_req", 32'(mem_req), 1);
      check("t3_addr", mem_addr, 32'h44);
      check("t3_wdata", mem_wdata, 32'h9999);
      check("t3_bmask", 32'(mem_bmask), 'hC);
      check("t3_we", 32'(mem_we), 0);
      tick();
    end
    @(negedge clk); check("t3_wait", 32'(mem_req), 0);
    drain("t3");

    // timeout, then response landing on the last counter value
    resp_en = 1'b0;
    tick(); ls_req = 1'b1; ls_addr = 32'h80; ls_wdata = '0; ls_bmask = 4'hF;
    push_exp(1'b1, 32'd0, 1'b1);
    @(negedge clk); check("t4_gnt", 32'(ls_gnt), 1);
    tick(); ls_req = 1'b0;
    @(negedge clk); check("t4_issue", 32'(mem_req & mem_ready), 1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 6) begin
        ls_req = 1'b1; ls_addr = 32'h84;
        push_exp(1'b1, 32'h0BADF00D, 1'b0);
      end
      @(negedge clk);
      check("t4_rv", 32'(ls_rvalid), 32'(k == 5));
      if (k == 5) begin resp_en = 1'b1; lat_cfg = 4; resp_data = 32'h0BADF00D; end
      if (k == 6) check("t4_idle_gnt", 32'(ls_gnt), 1);
    end
    tick(); ls_req = 1'b0;
    @(negedge clk); check("t4b_issue", 32'(mem_req & mem_ready), 1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      @(negedge clk);
      check("t4b_rv", 32'(ls_rvalid), 32'(k == 5));
    end
    lat_cfg = 1;
    drain("t4");

    // reset during WAIT, then a late response
    resp_en = 1'b0; resp_data = 32'h77777777;
    tick(); ls_req = 1'b1; ls_addr = 32'h88;
    @(negedge clk); check("t5_gnt", 32'(ls_gnt), 1);
    tick(); ls_req = 1'b0;
    @(negedge clk); check("t5_issue", 32'(mem_req), 1);
    tick(); rst = 1'b1;
    @(negedge clk); check("t5_rv_wait", 32'({if_rvalid, ls_rvalid}), 0); inject_rv = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk); check_outputs_zero("t5");
    tick();
    @(negedge clk); check("t5_rv_late", 32'({if_rvalid, ls_rvalid}), 0);
    resp_en = 1'b1; resp_data = 32'h13579BDF;
    tick(); ls_req = 1'b1; if_req = 1'b1; ls_addr = 32'h90; if_addr = 32'h94;
    push_exp(1'b1, 32'h13579BDF, 1'b0); push_exp(1'b0, 32'h13579BDF, 1'b0);
    @(negedge clk);
    check("t5_first_ls", 32'(ls_gnt), 1);
    check("t5_if_held", 32'(if_gnt), 0);
    tick(); ls_req = 1'b0;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!if_gnt && w < 10);
    check("t5_if_gnt", 32'(if_gnt), 1);
    check("t5_if_gap", w, 4);
    tick(); if_req = 1'b0;
    drain("t5");

    // stray response while idle
    inject_rv = 1'b1; resp_data = 32'hFFFF0000;
    tick();
    @(negedge clk);
    check("t6_rv", 32'({if_rvalid, ls_rvalid}), 0);
    check("t6_mem_req", 32'(mem_req), 0);
    tick();
    @(negedge clk);
    check("t6_rv2", 32'({if_rvalid, ls_rvalid}), 0);
    resp_data = 32'h24681357;
    tick(); if_req = 1'b1; if_addr = 32'h400; push_exp(1'b0, 32'h24681357, 1'b0);
    @(negedge clk); check("t6_gnt", 32'(if_gnt), 1);
    tick(); if_req = 1'b0;
    drain("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arb.md
# mem_port_arb

Arbiter and sequencer that shares the core's single unified memory port between instruction fetch (IF, read-only) and the load/store path (LS, read/write). It sits between the fetch/LSU logic driven by the decoder's `mem_re`/`mem_we` and the external memory. It issues one transaction at a time, tracks the outstanding response and returns data and completion to the requester that owns it. A response timeout guards against a hung memory.

## Interface
- `TIMEOUT_CYC`, default 64: cycles allowed in WAIT before an error completion; 0 disables the timeout.
- `i_clk` in 1: clock; everything is on the rising edge.
- `i_reset` in 1: synchronous, active-high reset.
- `i_if_req` in 1: IF read request; must be held stable with `i_if_addr` until `o_if_gnt`.
- `i_if_addr` in 32: IF word address.
- `o_if_gnt` out 1: one-cycle pulse; IF request accepted.
- `o_if_rvalid` out 1: one-cycle pulse; IF response.
- `o_if_rdata` out 32: IF read data.
- `o_if_err` out 1: IF timeout flag, valid with `o_if_rvalid`.
- `i_ls_req` in 1: LS request; `i_ls_we`/addr/wdata/bmask stable until `o_ls_gnt`.
- `i_ls_we` in 1: LS write (1) or read (0).
- `i_ls_addr` in 32: LS address.
- `i_ls_wdata` in 32: LS write data.
- `i_ls_bmask` in 4: LS byte enables.
- `o_ls_gnt`, `o_ls_rvalid`, `o_ls_rdata[31:0]`, `o_ls_err` out: same meaning as the IF outputs. `o_ls_rvalid` also marks write completion; `o_ls_rdata` is 0 for writes.
- `o_mem_req` out 1: downstream request valid.
- `o_mem_we` out 1: downstream write.
- `o_mem_addr` out 32, `o_mem_wdata` out 32, `o_mem_bmask` out 4: latched request fields. IF requests drive we=0, bmask=4'hF, wdata=0.
- `i_mem_ready` in 1: downstream accepts the request when `o_mem_req & i_mem_ready`.
- `i_mem_rvalid` in 1: downstream response for both reads and writes; arrives at least 1 cycle after acceptance.
- `i_mem_rdata` in 32: downstream read data, valid with `i_mem_rvalid`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. A 1-bit `owner` register (IF/LS) and a 1-bit `last_ls` register record grant history.
- **IDLE**
  - If any request is pending, grant it: pulse `o_x_gnt` combinationally this cycle, latch the request fields and `owner`, go to ISSUE.
  - With no request, stay in IDLE.
  - Priority: LS wins, except when both request and `last_ls`=1; then IF wins.
  - `last_ls` is updated on every grant (1 for LS, 0 for IF). Under sustained contention grants therefore alternate; IF never starves.
- **ISSUE**: `o_mem_req`=1 with the latched fields. On `i_mem_ready`, go to WAIT and clear the timeout counter. Otherwise hold all fields unchanged.
- **WAIT**
  - `o_mem_req`=0; the counter increments each cycle.
  - On `i_mem_rvalid`: latch `i_mem_rdata` (or 0 for a write), err=0, go to RESP.
  - Else if `TIMEOUT_CYC`≠0 and counter == `TIMEOUT_CYC`-1: rdata=0, err=1, go to RESP.
  - `i_mem_rvalid` takes precedence over timeout in the same cycle.
- **RESP**: pulse `o_owner_rvalid` with the latched rdata/err (the other requester's rvalid stays 0), then go to IDLE.
- `i_mem_rvalid` outside WAIT is ignored. The memory must not respond after a timeout.
- A requester dropping `req` before its grant is legal; the request is simply not granted.
- Counter width is `$clog2(TIMEOUT_CYC+1)`, minimum 1; it saturates and does not wrap.

## Timing
- Reset:
  - State = IDLE, `last_ls`=0 (LS wins first contention), counter=0, latched fields=0.
  - All outputs 0: gnt, rvalid, err, rdata, `o_mem_*`.
  - Reset in any state aborts the transaction with no rvalid; a response arriving after reset is ignored.
- Grant in cycle N (IDLE) means `o_mem_req` in N+1.
- With `i_mem_ready`=1 at N+1 and `i_mem_rvalid` at N+2, `o_x_rvalid` occurs at N+3. IDLE is reached at N+4, so the next grant is at N+4.
- Minimum issue-to-issue spacing is 4 cycles; at most one transaction is outstanding.
- `o_x_gnt` and `o_x_rvalid` are single-cycle pulses and never both asserted for the same requester in the same cycle.
- `o_mem_*` fields change only on the IDLE→ISSUE transition.

## Test plan
- **Single IF read**: `i_if_req`, addr 0x100; memory ready at once, rvalid 1 cycle later with 0xDEADBEEF. Required: `o_if_gnt`@N, `o_mem_req`@N+1 with addr 0x100, we=0, bmask F; `o_if_rvalid`@N+3 with rdata 0xDEADBEEF, err=0.
- **Contention**: IF and LS held requesting from reset. Required grant order LS, IF, LS, IF. Each LS write (addr 0x2000, wdata 0x11223344, bmask 4'b0011) completes with `o_ls_rvalid`, rdata 0.
- **Backpressure**: `i_mem_ready`=0 for 5 cycles in ISSUE. Required: `o_mem_req` and fields held constant for all 5 cycles; then WAIT on ready.
- **Timeout**: `TIMEOUT_CYC`=4 and no rvalid. Required: `o_ls_rvalid`=1, err=1, rdata=0 exactly 5 cycles after acceptance; FSM returns to IDLE. Also check rvalid arriving in the cycle the counter hits 3: err=0 and real data returned.
- **Reset mid-WAIT**: `i_reset` during WAIT, then `i_mem_rvalid` the next cycle. Required: no rvalid on either side; all outputs 0; first grant after reset goes to LS when both request.
- **Stray response**: `i_mem_rvalid` pulsed while in IDLE. Required: no `o_*_rvalid`, state unchanged.
